// File: rtl/axi_pkg.sv
// +--------------------------------------------------------------------+
// | axi_pkg : shared AXI response encodings                             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package axi_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t OKAY   = 2'b00;
  localparam axi_resp_t SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/tl_pkg.sv
// +--------------------------------------------------------------------+
// | tl_pkg : TileLink-UL opcode encodings and field widths              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package tl_pkg;

  localparam int SizeWidth = 3;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

endpackage

`default_nettype wire

// File: rtl/axi_lite_tl_adapter.sv
// +--------------------------------------------------------------------+
// | axi_lite_tl_adapter : AXI-Lite slave to TL-UL master, one in flight |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module axi_lite_tl_adapter
  import tl_pkg::*;
  import axi_pkg::*;
#(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     device_aw_valid,
  output logic                     device_aw_ready,
  input  logic [AddrWidth-1:0]     device_aw_addr,

  input  logic                     device_w_valid,
  output logic                     device_w_ready,
  input  logic [DataWidth-1:0]     device_w_data,
  input  logic [DataWidth/8-1:0]   device_w_strb,

  output logic                     device_b_valid,
  input  logic                     device_b_ready,
  output logic [1:0]               device_b_resp,

  input  logic                     device_ar_valid,
  output logic                     device_ar_ready,
  input  logic [AddrWidth-1:0]     device_ar_addr,

  output logic                     device_r_valid,
  input  logic                     device_r_ready,
  output logic [DataWidth-1:0]     device_r_data,
  output logic [1:0]               device_r_resp,

  output logic                     host_a_valid,
  input  logic                     host_a_ready,
  output logic [2:0]               host_a_opcode,
  output logic [2:0]               host_a_param,
  output logic [SizeWidth-1:0]     host_a_size,
  output logic [SourceWidth-1:0]   host_a_source,
  output logic [AddrWidth-1:0]     host_a_address,
  output logic [DataWidth/8-1:0]   host_a_mask,
  output logic [DataWidth-1:0]     host_a_data,
  output logic                     host_a_corrupt,

  input  logic                     host_b_valid,
  output logic                     host_b_ready,

  output logic                     host_c_valid,
  input  logic                     host_c_ready,

  input  logic                     host_d_valid,
  output logic                     host_d_ready,
  input  logic [2:0]               host_d_opcode,
  input  logic [1:0]               host_d_param,
  input  logic [SizeWidth-1:0]     host_d_size,
  input  logic [SourceWidth-1:0]   host_d_source,
  input  logic [0:0]               host_d_sink,
  input  logic                     host_d_denied,
  input  logic [DataWidth-1:0]     host_d_data,
  input  logic                     host_d_corrupt,

  output logic                     host_e_valid,
  input  logic                     host_e_ready
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int OffWidth  = $clog2(StrbWidth);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_REQ  = 2'd1,
    D_WAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   is_wr_q;
  logic                   last_wr_q;
  logic                   err_q;
  logic [DataWidth-1:0]   rdata_q;
  tl_a_op_e               a_opcode_q;
  logic [AddrWidth-1:0]   a_addr_q;
  logic [StrbWidth-1:0]   a_mask_q;
  logic [DataWidth-1:0]   a_data_q;

  logic                   aw_full_q, w_full_q, ar_full_q;
  logic [AddrWidth-1:0]   aw_addr_q, ar_addr_q;
  logic [DataWidth-1:0]   w_data_q;
  logic [StrbWidth-1:0]   w_strb_q;

  logic wr_pend, rd_pend, grant_wr, grant_rd, clr_wr, clr_rd;

  // Readies stay low for as long as reset is held, not just until the next edge.
  assign device_aw_ready = ~aw_full_q & ~rst_i;
  assign device_w_ready  = ~w_full_q  & ~rst_i;
  assign device_ar_ready = ~ar_full_q & ~rst_i;

  assign wr_pend  = aw_full_q & w_full_q;
  assign rd_pend  = ar_full_q;
  assign grant_rd = rd_pend & (~wr_pend | last_wr_q);
  assign grant_wr = wr_pend & ~grant_rd;

  assign clr_wr = (state_q == RESP) &  is_wr_q & device_b_ready;
  assign clr_rd = (state_q == RESP) & ~is_wr_q & device_r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (device_aw_valid && device_aw_ready) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= {device_aw_addr[AddrWidth-1:OffWidth], {OffWidth{1'b0}}};
      end else if (clr_wr) begin
        aw_full_q <= 1'b0;
      end
      if (device_w_valid && device_w_ready) begin
        w_full_q <= 1'b1;
        w_data_q <= device_w_data;
        w_strb_q <= device_w_strb;
      end else if (clr_wr) begin
        w_full_q <= 1'b0;
      end
      if (device_ar_valid && device_ar_ready) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= {device_ar_addr[AddrWidth-1:OffWidth], {OffWidth{1'b0}}};
      end else if (clr_rd) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      last_wr_q  <= 1'b1;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      a_opcode_q <= Get;
      a_addr_q   <= '0;
      a_mask_q   <= '0;
      a_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            is_wr_q <= 1'b1;
            err_q   <= 1'b0;
            // An all-zero strobe writes nothing, so it is acknowledged without a TL beat.
            if (w_strb_q == '0) begin
              state_q <= RESP;
            end else begin
              a_opcode_q <= (&w_strb_q) ? PutFullData : PutPartialData;
              a_addr_q   <= aw_addr_q;
              a_mask_q   <= w_strb_q;
              a_data_q   <= w_data_q;
              state_q    <= A_REQ;
            end
          end else if (grant_rd) begin
            is_wr_q    <= 1'b0;
            a_opcode_q <= Get;
            a_addr_q   <= ar_addr_q;
            a_mask_q   <= '1;
            a_data_q   <= '0;
            state_q    <= A_REQ;
          end
        end
        A_REQ: begin
          if (host_a_ready) state_q <= D_WAIT;
        end
        D_WAIT: begin
          if (host_d_valid) begin
            rdata_q <= host_d_data;
            err_q   <= host_d_denied | host_d_corrupt;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (clr_wr || clr_rd) begin
            last_wr_q <= is_wr_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_a_valid   = (state_q == A_REQ);
  assign host_a_opcode  = a_opcode_q;
  assign host_a_param   = 3'b000;
  assign host_a_size    = SizeWidth'(OffWidth);
  assign host_a_source  = '0;
  assign host_a_address = a_addr_q;
  assign host_a_mask    = a_mask_q;
  assign host_a_data    = a_data_q;
  assign host_a_corrupt = 1'b0;

  assign host_d_ready   = (state_q == D_WAIT);

  assign device_b_valid = (state_q == RESP) &  is_wr_q;
  assign device_r_valid = (state_q == RESP) & ~is_wr_q;
  assign device_b_resp  = err_q ? SLVERR : OKAY;
  assign device_r_resp  = err_q ? SLVERR : OKAY;
  assign device_r_data  = rdata_q;

  assign host_b_ready = 1'b1;
  assign host_c_valid = 1'b0;
  assign host_e_valid = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_tl_adapter.sv
// +--------------------------------------------------------------------+
// | tb_axi_lite_tl_adapter : directed self-checking bench for adapter   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_axi_lite_tl_adapter;

  localparam int DW = 64;
  localparam int AW = 56;
  localparam int SW = 1;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          aw_valid = 0, aw_ready;
  logic [AW-1:0] aw_addr = '0;
  logic          w_valid = 0, w_ready;
  logic [DW-1:0] w_data = '0;
  logic [7:0]    w_strb = '0;
  logic          b_valid, b_ready = 0;
  logic [1:0]    b_resp;
  logic          ar_valid = 0, ar_ready;
  logic [AW-1:0] ar_addr = '0;
  logic          r_valid, r_ready = 0;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;

  logic          a_valid, a_ready = 0;
  logic [2:0]    a_opcode, a_param, a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [7:0]    a_mask;
  logic [DW-1:0] a_data;
  logic          a_corrupt;
  logic          b_ch_valid = 0, b_ch_ready;
  logic          c_valid, c_ready = 1;
  logic          d_valid = 0, d_ready;
  logic [2:0]    d_opcode = '0;
  logic [1:0]    d_param = '0;
  logic [2:0]    d_size = 3'd3;
  logic [SW-1:0] d_source = '0;
  logic [0:0]    d_sink = '0;
  logic          d_denied = 0, d_corrupt = 0;
  logic [DW-1:0] d_data = '0;
  logic          e_valid, e_ready = 1;

  int compared = 0;
  int mismatched = 0;

  axi_lite_tl_adapter #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .device_aw_valid(aw_valid), .device_aw_ready(aw_ready), .device_aw_addr(aw_addr),
    .device_w_valid(w_valid), .device_w_ready(w_ready), .device_w_data(w_data), .device_w_strb(w_strb),
    .device_b_valid(b_valid), .device_b_ready(b_ready), .device_b_resp(b_resp),
    .device_ar_valid(ar_valid), .device_ar_ready(ar_ready), .device_ar_addr(ar_addr),
    .device_r_valid(r_valid), .device_r_ready(r_ready), .device_r_data(r_data), .device_r_resp(r_resp),
    .host_a_valid(a_valid), .host_a_ready(a_ready), .host_a_opcode(a_opcode), .host_a_param(a_param),
    .host_a_size(a_size), .host_a_source(a_source), .host_a_address(a_address), .host_a_mask(a_mask),
    .host_a_data(a_data), .host_a_corrupt(a_corrupt),
    .host_b_valid(b_ch_valid), .host_b_ready(b_ch_ready),
    .host_c_valid(c_valid), .host_c_ready(c_ready),
    .host_d_valid(d_valid), .host_d_ready(d_ready), .host_d_opcode(d_opcode), .host_d_param(d_param),
    .host_d_size(d_size), .host_d_source(d_source), .host_d_sink(d_sink), .host_d_denied(d_denied),
    .host_d_data(d_data), .host_d_corrupt(d_corrupt),
    .host_e_valid(e_valid), .host_e_ready(e_ready)
  );

  // ---- stimulus helpers (no checking inside) ----
  task automatic send_rd(input logic [AW-1:0] addr);
    ar_valid = 1; ar_addr = addr;
    @(negedge clk);
    ar_valid = 0;
  endtask

  task automatic send_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [7:0] strb);
    aw_valid = 1; aw_addr = addr; w_valid = 1; w_data = data; w_strb = strb;
    @(negedge clk);
    aw_valid = 0; w_valid = 0;
  endtask

  task automatic wait_a(output int cyc, output bit ok);
    cyc = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_valid) begin ok = 1; break; end
      @(negedge clk); cyc++;
    end
  endtask

  task automatic serve_a(input logic [2:0] op, input logic [DW-1:0] data,
                         input logic den, input logic cor, output bit ok);
    ok = 0;
    a_ready = 1;
    @(negedge clk);
    a_ready = 0;
    d_valid = 1; d_opcode = op; d_data = data; d_denied = den; d_corrupt = cor;
    for (int i = 0; i < 10; i++) begin
      if (d_ready) begin ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    d_valid = 0; d_denied = 0; d_corrupt = 0;
  endtask

  task automatic take_resp(input bit is_wr, output int cyc, output logic [1:0] resp,
                           output logic [DW-1:0] data, output bit ok);
    cyc = 0; ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (is_wr ? b_valid : r_valid) begin ok = 1; break; end
      @(negedge clk); cyc++;
    end
    resp = is_wr ? b_resp : r_resp;
    data = r_data;
    if (ok) begin
      if (is_wr) b_ready = 1; else r_ready = 1;
      @(negedge clk);
      b_ready = 0; r_ready = 0;
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    @(negedge clk);
    compared++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
      mismatched++; $display("FAIL reset_readies: got %b want 000", {aw_ready, w_ready, ar_ready});
    end
    compared++;
    if ({a_valid, b_valid, r_valid, d_ready} !== 4'b0000) begin
      mismatched++; $display("FAIL reset_valids: got %b want 0000", {a_valid, b_valid, r_valid, d_ready});
    end
    compared++;
    if ({b_ch_ready, c_valid, e_valid} !== 3'b100) begin
      mismatched++; $display("FAIL tie_offs: got %b want 100", {b_ch_ready, c_valid, e_valid});
    end
    rst_i = 0;
    #1;
    compared++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
      mismatched++; $display("FAIL release_readies: got %b want 111", {aw_ready, w_ready, ar_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_single_read;
    int cyc; bit ok; logic [1:0] resp; logic [DW-1:0] data;
    send_rd(56'h1004);
    wait_a(cyc, ok);
    compared++;
    if (!ok || cyc + 1 != 2) begin
      mismatched++; $display("FAIL rd_a_latency: got ok=%0d cycles=%0d want 2", ok, cyc + 1);
    end
    compared++;
    if ({a_opcode, a_size, a_mask, a_param} !== {3'd4, 3'd3, 8'hFF, 3'd0}) begin
      mismatched++; $display("FAIL rd_get_fields: got op=%0d size=%0d mask=%h param=%0d want 4 3 ff 0",
                             a_opcode, a_size, a_mask, a_param);
    end
    compared++;
    if (a_address !== 56'h1000 || a_source !== 1'b0) begin
      mismatched++; $display("FAIL rd_get_addr: got %h src=%0d want 1000 src=0", a_address, a_source);
    end
    serve_a(3'd1, 64'hDEADBEEF_CAFEF00D, 0, 0, ok);
    take_resp(0, cyc, resp, data, ok);
    compared++;
    if (!ok || cyc != 0) begin
      mismatched++; $display("FAIL rd_r_latency: got ok=%0d extra=%0d want r_valid 1 cycle after D", ok, cyc);
    end
    compared++;
    if (data !== 64'hDEADBEEF_CAFEF00D || resp !== 2'b00) begin
      mismatched++; $display("FAIL rd_r_payload: got %h resp=%b want deadbeefcafef00d 00", data, resp);
    end
    compared++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      mismatched++; $display("FAIL rd_done: got r_valid=%b ar_ready=%b want 0 1", r_valid, ar_ready);
    end
  endtask

  task automatic test_w_before_aw;
    int cyc; bit ok; bit seen_a; logic [1:0] resp; logic [DW-1:0] data;
    w_valid = 1; w_data = 64'h11223344_55667788; w_strb = 8'h0F;
    @(negedge clk);
    w_valid = 0;
    seen_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_valid) seen_a = 1;
    end
    compared++;
    if (seen_a !== 1'b0) begin
      mismatched++; $display("FAIL wfirst_early_a: got a_valid before AW want none");
    end
    aw_valid = 1; aw_addr = 56'h200C;
    @(negedge clk);
    aw_valid = 0;
    wait_a(cyc, ok);
    compared++;
    if (!ok || a_opcode !== 3'd1 || a_mask !== 8'h0F) begin
      mismatched++; $display("FAIL wfirst_partial: got ok=%0d op=%0d mask=%h want 1 1 0f", ok, a_opcode, a_mask);
    end
    compared++;
    if (a_address !== 56'h2008 || a_data !== 64'h11223344_55667788) begin
      mismatched++; $display("FAIL wfirst_payload: got addr=%h data=%h want 2008 1122334455667788",
                             a_address, a_data);
    end
    serve_a(3'd0, '0, 0, 0, ok);
    take_resp(1, cyc, resp, data, ok);
    compared++;
    if (!ok || resp !== 2'b00) begin
      mismatched++; $display("FAIL wfirst_b: got ok=%0d resp=%b want 1 00", ok, resp);
    end
  endtask

  task automatic test_arbitration;
    int cyc; bit ok; logic [1:0] resp; logic [DW-1:0] data;
    for (int rep = 0; rep < 2; rep++) begin
      ar_valid = 1; ar_addr = 56'h4000 + 56'(rep * 8);
      send_wr(56'h5000 + 56'(rep * 8), 64'hA5A5A5A5_00000000 + 64'(rep), 8'hFF);
      ar_valid = 0;
      for (int k = 0; k < 2; k++) begin
        wait_a(cyc, ok);
        compared++;
        if (!ok || a_opcode !== ((k == 0) ? 3'd4 : 3'd0)) begin
          mismatched++; $display("FAIL arb_order rep%0d slot%0d: got ok=%0d op=%0d want %0d",
                                 rep, k, ok, a_opcode, (k == 0) ? 4 : 0);
        end
        serve_a((k == 0) ? 3'd1 : 3'd0, 64'h0000_0000_0000_1234, 0, 0, ok);
        take_resp(k == 1, cyc, resp, data, ok);
        compared++;
        if (!ok || resp !== 2'b00) begin
          mismatched++; $display("FAIL arb_resp rep%0d slot%0d: got ok=%0d resp=%b want 1 00", rep, k, ok, resp);
        end
      end
    end
  endtask

  task automatic test_errors;
    int cyc; bit ok; logic [1:0] resp; logic [DW-1:0] data;
    send_rd(56'h40);
    wait_a(cyc, ok);
    serve_a(3'd1, 64'h0, 1, 0, ok);
    take_resp(0, cyc, resp, data, ok);
    compared++;
    if (!ok || resp !== 2'b10) begin
      mismatched++; $display("FAIL err_denied_r: got ok=%0d resp=%b want 1 10", ok, resp);
    end
    send_wr(56'h80, 64'h5555, 8'hFF);
    wait_a(cyc, ok);
    serve_a(3'd0, 64'h0, 0, 1, ok);
    take_resp(1, cyc, resp, data, ok);
    compared++;
    if (!ok || resp !== 2'b10) begin
      mismatched++; $display("FAIL err_corrupt_b: got ok=%0d resp=%b want 1 10", ok, resp);
    end
  endtask

  task automatic test_zero_strb;
    int cyc; bit got_b; bit seen_a; logic [1:0] resp;
    aw_valid = 1; aw_addr = 56'h3000; w_valid = 1; w_data = 64'hFFFF; w_strb = 8'h00;
    cyc = 0; got_b = 0; seen_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cyc++;
      aw_valid = 0; w_valid = 0;
      if (a_valid) seen_a = 1;
      if (b_valid) begin got_b = 1; break; end
    end
    resp = b_resp;
    compared++;
    if (!got_b || seen_a) begin
      mismatched++; $display("FAIL zstrb_local: got b=%0d a_seen=%0d cycles=%0d want b within 3, no A",
                             got_b, seen_a, cyc);
    end
    compared++;
    if (resp !== 2'b00) begin
      mismatched++; $display("FAIL zstrb_resp: got %b want 00", resp);
    end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
  endtask

  task automatic test_reset_mid;
    int cyc; bit ok; bit stale; logic [1:0] resp; logic [DW-1:0] data;
    send_rd(56'h6000);
    wait_a(cyc, ok);
    a_ready = 1;
    @(negedge clk);
    a_ready = 0;
    compared++;
    if (d_ready !== 1'b1) begin
      mismatched++; $display("FAIL mid_d_wait: got d_ready=%b want 1", d_ready);
    end
    #2 rst_i = 1;
    #1;
    compared++;
    if ({a_valid, b_valid, r_valid, d_ready, ar_ready} !== 5'b00000) begin
      mismatched++; $display("FAIL mid_reset_low: got %b want 00000", {a_valid, b_valid, r_valid, d_ready, ar_ready});
    end
    @(negedge clk); @(negedge clk);
    rst_i = 0;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b_valid || r_valid || a_valid) stale = 1;
    end
    compared++;
    if (stale) begin
      mismatched++; $display("FAIL mid_stale: got a stale valid after release want none");
    end
    send_rd(56'h7008);
    wait_a(cyc, ok);
    compared++;
    if (!ok || a_address !== 56'h7008) begin
      mismatched++; $display("FAIL mid_fresh_a: got ok=%0d addr=%h want 1 7008", ok, a_address);
    end
    serve_a(3'd1, 64'h01234567_89ABCDEF, 0, 0, ok);
    take_resp(0, cyc, resp, data, ok);
    compared++;
    if (!ok || data !== 64'h01234567_89ABCDEF || resp !== 2'b00) begin
      mismatched++; $display("FAIL mid_fresh_r: got ok=%0d data=%h resp=%b want 1 0123456789abcdef 00",
                             ok, data, resp);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_w_before_aw();
    test_arbitration();
    test_errors();
    test_zero_strb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
